// File: rtl/upscal_pkg.sv
// rtl/upscal_pkg.sv - shared memory-port constants, fetch FSM states and burst sizing helper
package upscal_pkg;

  localparam int MEM_AW    = 23;
  localparam int MEM_DW    = 32;
  localparam int MEM_BURST = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Words to the next 4-word boundary, clipped to what is left of the line.
  function automatic logic [2:0] burst_words(input logic [1:0] addr_lo, input logic [11:0] left);
    logic [2:0] to_bound;
    to_bound = 3'(MEM_BURST) - {1'b0, addr_lo};
    return (left < {9'd0, to_bound}) ? left[2:0] : to_bound;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock show-ahead FIFO with occupancy count
module fifo_sync #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign do_wr   = wr_en && (count != (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/line_fetch.sv
// rtl/line_fetch.sv - strided line fetcher: aligned read bursts into a credit-checked output FIFO
// Optional starvation counter built only when LINE_FETCH_STATS_EN is defined.
module line_fetch
  import upscal_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MEM_AW-1:0] base,
  input  logic [MEM_AW-1:0] stride,
  input  logic [11:0]       width,
  input  logic [11:0]       lines,
  output logic              busy,
  output logic              done,
  output logic [MEM_AW-1:0] memaddr,
  output logic [1:0]        memlen,
  output logic              memwr,
  output logic              memreq,
  input  logic              memready,
  input  logic              memack,
  input  logic [MEM_DW-1:0] memrdata,
  output logic [MEM_DW-1:0] odata,
  output logic              ovalid,
  input  logic              oready,
  output logic              olast,
  output logic [15:0]       stall_cycles
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [MEM_AW-1:0] stride_r;
  logic [MEM_AW-1:0] line_addr;
  logic [MEM_AW-1:0] cur_addr;
  logic [11:0]       width_r;
  logic [11:0]       lines_r;
  logic [11:0]       line_idx;
  logic [11:0]       word_idx;
  logic [11:0]       rword;
  logic [CW-1:0]     outst;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       avail;
  logic [2:0]        blen;
  logic [MEM_DW:0]   fifo_rdata;
  logic              fifo_empty;
  logic              accept;
  logic              ack_ok;
  logic              pop;
  logic              start_ok;
  logic              line_end;
  logic              last_line;
  logic              word_last;

  assign cur_addr  = line_addr + {11'd0, word_idx};
  assign blen      = burst_words(cur_addr[1:0], width_r - word_idx);
  // Space not yet claimed by in-flight words; a burst only goes out if it fits.
  assign avail     = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} - {1'b0, outst};
  assign memreq    = (state == ST_REQ) && (avail >= (CW+1)'(blen));
  assign accept    = memreq && memready;
  assign ack_ok    = memack && (outst != '0);
  assign ovalid    = !fifo_empty;
  assign pop       = ovalid && oready;
  assign done      = pop && (state == ST_DRAIN) && (outst == '0) && (fifo_count == CW'(1));
  assign busy      = (state != ST_IDLE) && !done;
  assign start_ok  = start && (state == ST_IDLE);
  assign line_end  = ({1'b0, word_idx} + {10'd0, blen}) == {1'b0, width_r};
  assign last_line = (line_idx == lines_r - 12'd1);
  assign word_last = (rword == width_r - 12'd1);
  assign memaddr   = (state == ST_REQ) ? cur_addr : '0;
  assign memlen    = (state == ST_REQ) ? 2'(blen - 3'd1) : 2'd0;
  assign memwr     = 1'b0;
  assign odata     = fifo_rdata[MEM_DW-1:0];
  assign olast     = ovalid && fifo_rdata[MEM_DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      stride_r  <= '0;
      line_addr <= '0;
      width_r   <= '0;
      lines_r   <= '0;
      line_idx  <= '0;
      word_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_ok) begin
          stride_r  <= stride;
          line_addr <= base;
          width_r   <= width;
          lines_r   <= lines;
          line_idx  <= '0;
          word_idx  <= '0;
          state     <= ST_REQ;
        end
        ST_REQ: if (accept) begin
          if (!line_end) begin
            word_idx <= word_idx + 12'(blen);
          end else if (last_line) begin
            state <= ST_DRAIN;
          end else begin
            line_idx  <= line_idx + 12'd1;
            line_addr <= line_addr + stride_r;
            word_idx  <= '0;
          end
        end
        ST_DRAIN: if (done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Returned words arrive in request order, so a running index tags line ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst <= '0;
      rword <= '0;
    end else begin
      outst <= outst + (accept ? CW'(blen) : CW'(0)) - (ack_ok ? CW'(1) : CW'(0));
      if (start_ok)    rword <= '0;
      else if (ack_ok) rword <= word_last ? 12'd0 : rword + 12'd1;
    end
  end

  fifo_sync #(
    .WIDTH(MEM_DW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (ack_ok),
    .wr_data({word_last, memrdata}),
    .rd_en  (pop),
    .rd_data(fifo_rdata),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

`ifdef LINE_FETCH_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                         stall_q <= '0;
    else if (start_ok)                                               stall_q <= '0;
    else if (busy && oready && !ovalid && (stall_q != 16'hFFFF))     stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: doc/line_fetch.md
LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, output FIFO depth in 32-bit words (power of two, >=8).
REQ-002 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge
 rst  in  1  reset, asynchronous, active-high
 start  in  1  one-cycle pulse, begin transfer (ignored while busy)
 base  in  23  word address of first word of line 0
 stride  in  23  word-address increment between line starts
 width  in  12  words per line, 1..4095
 lines  in  12  line count, 1..4095
 busy  out  1  transfer in progress
 done  out  1  one-cycle pulse when the last word leaves the FIFO
 memaddr  out  23  memory port word address
 memlen  out  2  burst length minus one
 memwr  out  1  tied 0 (read-only client)
 memreq  out  1  request valid
 memready  in  1  port can accept request
 memack  in  1  one pulse per returned read word
 memrdata  in  32  read word, valid with memack
 odata  out  32  output word
 ovalid  out  1  output word valid
 oready  in  1  consumer accepts word
 olast  out  1  odata is last word of a line
 stall_cycles  out  16  starvation counter (see REQ-019)

Function
REQ-003 SHALL latch base, stride, width, lines on start while busy=0; busy rises the next cycle.
REQ-004 SHALL run FSM IDLE -> REQ -> DRAIN -> IDLE; REQ issues bursts, DRAIN waits until outstanding=0 and FIFO empty.
REQ-005 SHALL treat a request as accepted only in a cycle with memreq=1 and memready=1; memaddr/memlen SHALL be held stable while memreq=1 and not accepted.
REQ-006 SHALL split each line into bursts of 1..4 words, no burst crossing a 4-word-aligned address boundary; burst length = min(4 - addr[1:0], words left in line).
REQ-007 SHALL never let a burst span two lines; line n starts at base + n*stride, 23-bit wrap-around arithmetic.
REQ-008 SHALL issue a burst only if FIFO free space minus outstanding words >= burst length (credit check); memreq SHALL be 0 otherwise.
REQ-009 SHALL count outstanding words: +len on acceptance, -1 per memack, both in one cycle allowed.
REQ-010 SHALL write memrdata into FIFO in the memack cycle; ovalid SHALL rise no earlier than the cycle after.
REQ-011 SHALL tag each FIFO word with olast, set on word index width-1 of each line.
REQ-012 SHALL move REQ -> DRAIN on acceptance of the final burst of the final line.
REQ-013 SHALL pulse done and drop busy in the same cycle the last word is popped (ovalid & oready & final word).
REQ-014 SHALL treat memack while outstanding=0 as a protocol error: word dropped, counter not decremented.
REQ-015 SHALL ignore start while busy=1; start in the done cycle is ignored.

Reset
REQ-016 SHALL on rst: FSM IDLE, busy=0, done=0, memreq=0, memlen=0, memaddr=0, ovalid=0, olast=0, FIFO empty, outstanding=0, stall_cycles=0.
REQ-017 SHALL abort any transfer on rst mid-operation; acks for bursts accepted before rst SHALL be discarded by REQ-014.
REQ-018 memwr SHALL be 0 at all times, including during reset.

Configuration
REQ-019 With LINE_FETCH_STATS_EN defined, stall_cycles SHALL increment (saturating at 16'hFFFF) each cycle busy=1, oready=1, ovalid=0, and clear on start acceptance; without it stall_cycles SHALL be constant 0 and no counter logic synthesized.

Structure
REQ-020 SHALL take MEM_AW=23, MEM_DW=32, MEM_BURST=4 and the FSM state enum from shared package upscal_pkg.
REQ-021 SHALL instantiate one sub-module fifo_sync (33-bit wide: data+last, FIFO_DEPTH deep, show-ahead, count output).

Verification
REQ-022 base=0x000002, stride=0x100, width=7, lines=1, memready=1, ack 3 cycles later -> bursts (0x000002,len1),(0x000004,len3),(0x000008,len0); 7 words out, olast on 7th, done once.
REQ-023 width=4, lines=3, base=0x7FFFFC, stride=4 -> line starts 0x7FFFFC, 0x000000, 0x000004 (wrap), three bursts len3, olast every 4th word.
REQ-024 FIFO_DEPTH=8, oready=0, width=64, lines=1 -> at most 8 words requested before first pop; memreq held low; no FIFO overflow.
REQ-025 memready=0 for 10 cycles during REQ -> memaddr/memlen stable all 10 cycles, single acceptance.
REQ-026 rst asserted after 2 bursts accepted, 3 acks pending -> outputs at reset values, pending acks dropped, new start runs normally.
REQ-027 STATS_EN build, ack delay 20 cycles, oready=1 -> stall_cycles >= 20 after first line; non-STATS build -> stall_cycles=0.
